// File: rtl/ps2_mouse_packet_decoder_pkg.sv
// ps2_mouse_packet_decoder_pkg: shared FSM states, byte0 field layout and cursor arithmetic width
package ps2_mouse_packet_decoder_pkg;
  localparam int PKT_BYTES = 3;
  localparam int SYNC_BIT = 3;
  localparam int XSIGN = 4;
  localparam int YSIGN = 5;
  localparam int XOVF = 6;
  localparam int YOVF = 7;
  localparam int CW = 12;
  typedef enum logic [$clog2(PKT_BYTES)-1:0] {WAIT_B0, WAIT_B1, WAIT_B2} state_e;
  typedef struct packed {
    logic       yovf;
    logic       xovf;
    logic       ysign;
    logic       xsign;
    logic [2:0] btn;
  } hdr_t;
  function automatic logic signed [CW-1:0] sext9(input logic [8:0] v);
    return {{(CW-9){v[8]}}, v};
  endfunction
endpackage

// File: rtl/ps2_mouse_packet_decoder_if.sv
// ps2_mouse_packet_decoder_if: byte strobe in (valid/data/err), decoded packet + cursor + sync_err out
interface ps2_mouse_packet_decoder_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_err;
  logic       pkt_valid;
  logic [2:0] buttons;
  logic [8:0] dx;
  logic [8:0] dy;
  logic       x_ovf;
  logic       y_ovf;
  logic [9:0] cursor_x;
  logic [9:0] cursor_y;
  logic       sync_err;
  modport master (
    output byte_valid, byte_data, byte_err,
    input  pkt_valid, buttons, dx, dy, x_ovf, y_ovf, cursor_x, cursor_y, sync_err
  );
  modport slave (
    input  byte_valid, byte_data, byte_err,
    output pkt_valid, buttons, dx, dy, x_ovf, y_ovf, cursor_x, cursor_y, sync_err
  );
endinterface

// File: rtl/ps2_mouse_packet_decoder_accum.sv
// ps2_axis_accum: saturating cursor axis; clk_i/rst_i, en_i adds signed delta_i, pos_o clamped to 0..MAX
module ps2_axis_accum
  import ps2_mouse_packet_decoder_pkg::*;
#(
  parameter int MAX  = 639,
  parameter int INIT = 320
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic signed [CW-1:0] delta_i,
  output logic [9:0]           pos_o
);
  logic [9:0] pos_q, pos_d;
  logic signed [CW-1:0] sum;
  always_comb begin
    sum   = $signed({{(CW-10){1'b0}}, pos_q}) + delta_i;
    pos_d = !en_i ? pos_q : sum < 0 ? '0 : sum > MAX ? 10'(MAX) : sum[9:0];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) pos_q <= 10'(INIT);
    else pos_q <= pos_d;
  end
  assign pos_o = pos_q;
endmodule

// File: rtl/ps2_mouse_packet_decoder.sv
// ps2_mouse_packet_decoder: 3-byte PS/2 mouse packet assembler/decoder with clamped cursor; clk_i, rst_i, bus (slave)
module ps2_mouse_packet_decoder
  import ps2_mouse_packet_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int X_INIT         = 320,
  parameter int Y_INIT         = 240
) (
  input logic                        clk_i,
  input logic                        rst_i,
  ps2_mouse_packet_decoder_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_e state_q, state_d;
  hdr_t hdr_q, hdr_d;
  logic [7:0] b1_q, b1_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic pkt_q, pkt_d, err_q, err_d;
  logic [2:0] btn_q;
  logic [8:0] dx_q, dy_q;
  logic xo_q, yo_q;
  logic vld, accept, expired;
  logic signed [CW-1:0] dx_w, dy_w;
  assign vld     = bus.byte_valid;
  assign accept  = vld && !bus.byte_err && (state_q != WAIT_B0 || bus.byte_data[SYNC_BIT]);
  assign expired = state_q != WAIT_B0 && tmo_q == TW'(TIMEOUT_CYCLES - 1);
  assign dx_w    = sext9({hdr_q.xsign, b1_q});
  assign dy_w    = sext9({hdr_q.ysign, bus.byte_data});
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= WAIT_B0;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (state_q == WAIT_B0) state_d = accept ? WAIT_B1 : WAIT_B0;
    else if (vld) state_d = (accept && state_q == WAIT_B1) ? WAIT_B2 : WAIT_B0;
    else if (expired) state_d = WAIT_B0;
  end
  // A byte arriving in the expiry cycle takes the vld branch, so it wins over the timeout.
  always_comb begin
    pkt_d = accept && state_q == WAIT_B2;
    err_d = vld ? !accept : expired;
    tmo_d = (vld || expired || state_q == WAIT_B0) ? '0 : tmo_q + 1'b1;
    hdr_d = (accept && state_q == WAIT_B0)
          ? hdr_t'({bus.byte_data[YOVF], bus.byte_data[XOVF], bus.byte_data[YSIGN],
                    bus.byte_data[XSIGN], bus.byte_data[2:0]})
          : hdr_q;
    b1_d  = (accept && state_q == WAIT_B1) ? bus.byte_data : b1_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hdr_q <= '0;
      b1_q  <= '0;
      tmo_q <= '0;
      pkt_q <= 1'b0;
      err_q <= 1'b0;
      btn_q <= '0;
      dx_q  <= '0;
      dy_q  <= '0;
      xo_q  <= 1'b0;
      yo_q  <= 1'b0;
    end else begin
      hdr_q <= hdr_d;
      b1_q  <= b1_d;
      tmo_q <= tmo_d;
      pkt_q <= pkt_d;
      err_q <= err_d;
      if (pkt_d) begin
        btn_q <= hdr_q.btn;
        dx_q  <= {hdr_q.xsign, b1_q};
        dy_q  <= {hdr_q.ysign, bus.byte_data};
        xo_q  <= hdr_q.xovf;
        yo_q  <= hdr_q.yovf;
      end
    end
  end
  ps2_axis_accum #(.MAX(SCREEN_W - 1), .INIT(X_INIT)) u_x (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(pkt_d && !hdr_q.xovf), .delta_i(dx_w), .pos_o(bus.cursor_x)
  );
  // Screen rows grow downward while +dy means up, so Y integrates -dy.
  ps2_axis_accum #(.MAX(SCREEN_H - 1), .INIT(Y_INIT)) u_y (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(pkt_d && !hdr_q.yovf), .delta_i(-dy_w), .pos_o(bus.cursor_y)
  );
  assign bus.pkt_valid = pkt_q;
  assign bus.sync_err  = err_q;
  assign bus.buttons   = btn_q;
  assign bus.dx        = dx_q;
  assign bus.dy        = dy_q;
  assign bus.x_ovf     = xo_q;
  assign bus.y_ovf     = yo_q;
endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// tb_ps2_mouse_packet_decoder: directed self-checking bench for the PS/2 mouse packet decoder
module tb_ps2_mouse_packet_decoder;
  localparam int T = 20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  ps2_mouse_packet_decoder_if bus ();
  ps2_mouse_packet_decoder #(.TIMEOUT_CYCLES(T)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic e);
    bus.byte_valid = 1'b1;
    bus.byte_data  = d;
    bus.byte_err   = e;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.byte_err   = 1'b0;
  endtask
  task automatic pkt3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a, 1'b0);
    send(b, 1'b0);
    send(c, 1'b0);
  endtask
  task automatic exp_pkt(input string tag, input logic [2:0] btn, input logic [8:0] x, input logic [8:0] y,
                         input logic xo, input logic yo, input logic [9:0] cx, input logic [9:0] cy);
    chk({tag, ".pkt_valid"}, 32'(bus.pkt_valid), 32'd1);
    chk({tag, ".sync_err"}, 32'(bus.sync_err), 32'd0);
    chk({tag, ".buttons"}, 32'(bus.buttons), 32'(btn));
    chk({tag, ".dx"}, 32'(bus.dx), 32'(x));
    chk({tag, ".dy"}, 32'(bus.dy), 32'(y));
    chk({tag, ".x_ovf"}, 32'(bus.x_ovf), 32'(xo));
    chk({tag, ".y_ovf"}, 32'(bus.y_ovf), 32'(yo));
    chk({tag, ".cursor_x"}, 32'(bus.cursor_x), 32'(cx));
    chk({tag, ".cursor_y"}, 32'(bus.cursor_y), 32'(cy));
  endtask
  task automatic exp_rst(input string tag);
    chk({tag, ".pkt_valid"}, 32'(bus.pkt_valid), 32'd0);
    chk({tag, ".sync_err"}, 32'(bus.sync_err), 32'd0);
    chk({tag, ".buttons"}, 32'(bus.buttons), 32'd0);
    chk({tag, ".dx"}, 32'(bus.dx), 32'd0);
    chk({tag, ".dy"}, 32'(bus.dy), 32'd0);
    chk({tag, ".x_ovf"}, 32'(bus.x_ovf), 32'd0);
    chk({tag, ".y_ovf"}, 32'(bus.y_ovf), 32'd0);
    chk({tag, ".cursor_x"}, 32'(bus.cursor_x), 32'd320);
    chk({tag, ".cursor_y"}, 32'(bus.cursor_y), 32'd240);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    bus.byte_err   = 1'b0;
    repeat (2) @(negedge clk);
    exp_rst("reset");
    rst = 1'b0;
    pkt3(8'h08, 8'h05, 8'h03);
    exp_pkt("t1", 3'b000, 9'h005, 9'h003, 1'b0, 1'b0, 10'd325, 10'd237);
    @(negedge clk);
    chk("t1.pkt_valid_drop", 32'(bus.pkt_valid), 32'd0);
    chk("t1.hold_dx", 32'(bus.dx), 32'h005);
    do_reset();
    pkt3(8'h39, 8'hFB, 8'hFE);
    exp_pkt("t2", 3'b001, 9'h1FB, 9'h1FE, 1'b0, 1'b0, 10'd315, 10'd242);
    send(8'h00, 1'b0);
    chk("t3.sync_err_nosync", 32'(bus.sync_err), 32'd1);
    chk("t3.no_pkt", 32'(bus.pkt_valid), 32'd0);
    pkt3(8'h08, 8'h01, 8'h01);
    exp_pkt("t3", 3'b000, 9'h001, 9'h001, 1'b0, 1'b0, 10'd316, 10'd241);
    send(8'h08, 1'b1);
    chk("err_b0.sync_err", 32'(bus.sync_err), 32'd1);
    send(8'h08, 1'b0);
    chk("err_b1.first_ok", 32'(bus.sync_err), 32'd0);
    send(8'h05, 1'b1);
    chk("err_b1.sync_err", 32'(bus.sync_err), 32'd1);
    pkt3(8'h08, 8'h02, 8'h02);
    exp_pkt("err_b1.recover", 3'b000, 9'h002, 9'h002, 1'b0, 1'b0, 10'd318, 10'd239);
    send(8'h08, 1'b0);
    send(8'h10, 1'b0);
    repeat (T - 1) @(negedge clk);
    chk("t4.before_expiry", 32'(bus.sync_err), 32'd0);
    @(negedge clk);
    chk("t4.timeout_err", 32'(bus.sync_err), 32'd1);
    pkt3(8'h08, 8'h00, 8'h00);
    exp_pkt("t4.recover", 3'b000, 9'h000, 9'h000, 1'b0, 1'b0, 10'd318, 10'd239);
    send(8'h08, 1'b0);
    repeat (T - 1) @(negedge clk);
    send(8'h02, 1'b0);
    chk("race.no_err", 32'(bus.sync_err), 32'd0);
    send(8'h03, 1'b0);
    exp_pkt("race", 3'b000, 9'h002, 9'h003, 1'b0, 1'b0, 10'd320, 10'd236);
    do_reset();
    pkt3(8'h08, 8'hFF, 8'hEB);
    exp_pkt("t5.a", 3'b000, 9'h0FF, 9'h0EB, 1'b0, 1'b0, 10'd575, 10'd5);
    pkt3(8'h08, 8'h37, 8'h00);
    exp_pkt("t5.b", 3'b000, 9'h037, 9'h000, 1'b0, 1'b0, 10'd630, 10'd5);
    pkt3(8'h08, 8'h7F, 8'h7F);
    exp_pkt("t5.clamp", 3'b000, 9'h07F, 9'h07F, 1'b0, 1'b0, 10'd639, 10'd0);
    pkt3(8'h48, 8'h7F, 8'h00);
    exp_pkt("t5.xovf", 3'b000, 9'h07F, 9'h000, 1'b1, 1'b0, 10'd639, 10'd0);
    pkt3(8'hA8, 8'h00, 8'h80);
    exp_pkt("yovf", 3'b000, 9'h000, 9'h180, 1'b0, 1'b1, 10'd639, 10'd0);
    pkt3(8'h18, 8'h00, 8'h00);
    exp_pkt("xneg.1", 3'b000, 9'h100, 9'h000, 1'b0, 1'b0, 10'd383, 10'd0);
    pkt3(8'h18, 8'h00, 8'h00);
    exp_pkt("xneg.2", 3'b000, 9'h100, 9'h000, 1'b0, 1'b0, 10'd127, 10'd0);
    pkt3(8'h18, 8'h00, 8'h00);
    exp_pkt("xneg.clamp", 3'b000, 9'h100, 9'h000, 1'b0, 1'b0, 10'd0, 10'd0);
    pkt3(8'h28, 8'h00, 8'h00);
    exp_pkt("ydown.1", 3'b000, 9'h000, 9'h100, 1'b0, 1'b0, 10'd0, 10'd256);
    pkt3(8'h2F, 8'h00, 8'h00);
    exp_pkt("ydown.clamp", 3'b111, 9'h000, 9'h100, 1'b0, 1'b0, 10'd0, 10'd479);
    send(8'h08, 1'b0);
    send(8'h05, 1'b0);
    do_reset();
    exp_rst("t6.reset");
    pkt3(8'h08, 8'h01, 8'h02);
    exp_pkt("t6.new", 3'b000, 9'h001, 9'h002, 1'b0, 1'b0, 10'd321, 10'd238);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
